// File: rtl/fmac_saddr_filter_pkg.sv
// Shared encodings and widths for the multicast source-address filter.
package fmac_saddr_filter_pkg;

  localparam int MAC_ADDR_W = 48;
  localparam int DROP_CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE = 3'b001,
    ST_SCAN = 3'b010,
    ST_DONE = 3'b100
  } state_e;

endpackage

// File: rtl/fmac_saddr_tbl.sv
// Allowed-address table: one write port, one combinational read port.
// Only entry-valid bits are reset; address storage holds whatever was last written.
module fmac_saddr_tbl
  import fmac_saddr_filter_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  wr_en,
  input  logic [IDX_W-1:0]      wr_idx,
  input  logic [MAC_ADDR_W-1:0] wr_addr,
  input  logic                  wr_ena,
  input  logic [IDX_W-1:0]      rd_idx,
  output logic [MAC_ADDR_W-1:0] rd_addr,
  output logic                  rd_vld
);

  logic [MAC_ADDR_W-1:0] r_addr [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] r_vld;

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (wr_en && (wr_idx == IDX_W'(i))) begin
        r_addr[i] <= wr_addr;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_vld <= '0;
    end else begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (wr_en && (wr_idx == IDX_W'(i))) begin
          r_vld[i] <= wr_ena;
        end
      end
    end
  end

  // Reads see pre-write contents when a write to the same entry lands this cycle.
  assign rd_addr = r_addr[rd_idx];
  assign rd_vld  = r_vld[rd_idx];

endmodule

// File: rtl/fmac_saddr_filter_ctrl.sv
// Sequential source-address filter: one 48-bit comparator walks the table per frame.
// Optional drop statistics counter enabled by FMAC_SADDR_FILTER_STATS_EN.
module fmac_saddr_filter_ctrl
  import fmac_saddr_filter_pkg::*;
#(
  parameter int NUM_ENTRIES = 4,
  parameter int IDX_W       = 2
) (
  input  logic                  clk,
  input  logic                  rst_,
  input  logic                  mcast_en,
  input  logic                  cfg_wr,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [MAC_ADDR_W-1:0] cfg_addr,
  input  logic                  cfg_ena,
  input  logic [MAC_ADDR_W-1:0] mac_saddr,
  input  logic                  mac_saddr_vld,
`ifdef FMAC_SADDR_FILTER_STATS_EN
  input  logic                  drop_cnt_clr,
  output logic [DROP_CNT_W-1:0] drop_cnt,
`endif
  output logic                  filter_busy,
  output logic                  filter_done,
  output logic                  saddr_filter_drop,
  output logic [IDX_W-1:0]      filter_hit_idx,
  output logic [2:0]            dbg_state
);

  // Handshake: mac_saddr_vld is a one-cycle strobe, accepted only in IDLE and
  // silently ignored otherwise; filter_done is a one-cycle strobe with no
  // backpressure, and drop/hit_idx stay valid until the next done.

  state_e                r_state, w_state_nxt;
  logic [MAC_ADDR_W-1:0] r_sa, w_sa_nxt;
  logic [IDX_W-1:0]      r_scan_idx, w_scan_idx_nxt;
  logic                  r_drop, w_drop_nxt;
  logic [IDX_W-1:0]      r_hit_idx, w_hit_idx_nxt;

  logic [MAC_ADDR_W-1:0] w_ent_addr;
  logic                  w_ent_vld;
  logic                  w_hit;
  logic                  w_last;

  fmac_saddr_tbl #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) u_tbl (
    .clk     (clk),
    .rst_    (rst_),
    .wr_en   (cfg_wr),
    .wr_idx  (cfg_idx),
    .wr_addr (cfg_addr),
    .wr_ena  (cfg_ena),
    .rd_idx  (r_scan_idx),
    .rd_addr (w_ent_addr),
    .rd_vld  (w_ent_vld)
  );

  assign w_hit  = w_ent_vld && (w_ent_addr == r_sa);
  assign w_last = (r_scan_idx == IDX_W'(NUM_ENTRIES - 1));

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_state    <= ST_IDLE;
      r_scan_idx <= '0;
      r_drop     <= 1'b0;
      r_hit_idx  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_scan_idx <= w_scan_idx_nxt;
      r_drop     <= w_drop_nxt;
      r_hit_idx  <= w_hit_idx_nxt;
    end
  end

  // The latched source address needs no reset; it is only read in SCAN.
  always_ff @(posedge clk) begin
    r_sa <= w_sa_nxt;
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_sa_nxt       = r_sa;
    w_scan_idx_nxt = r_scan_idx;
    w_drop_nxt     = r_drop;
    w_hit_idx_nxt  = r_hit_idx;
    case (r_state)
      ST_IDLE: begin
        if (mac_saddr_vld) begin
          w_sa_nxt = mac_saddr;
          if (!mcast_en) begin
            w_state_nxt   = ST_DONE;
            w_drop_nxt    = 1'b0;
            w_hit_idx_nxt = '0;
          end else begin
            w_state_nxt    = ST_SCAN;
            w_scan_idx_nxt = '0;
          end
        end
      end
      ST_SCAN: begin
        if (w_hit) begin
          w_state_nxt   = ST_DONE;
          w_drop_nxt    = 1'b0;
          w_hit_idx_nxt = r_scan_idx;
        end else if (w_last) begin
          w_state_nxt   = ST_DONE;
          w_drop_nxt    = 1'b1;
          w_hit_idx_nxt = '0;
        end else begin
          w_scan_idx_nxt = r_scan_idx + IDX_W'(1);
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign filter_done       = (r_state == ST_DONE);
  assign filter_busy       = (r_state == ST_SCAN) || (r_state == ST_DONE);
  assign saddr_filter_drop = r_drop;
  assign filter_hit_idx    = r_hit_idx;
  assign dbg_state         = r_state;

`ifdef FMAC_SADDR_FILTER_STATS_EN
  logic [DROP_CNT_W-1:0] r_drop_cnt;

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      r_drop_cnt <= '0;
    end else if (drop_cnt_clr) begin
      r_drop_cnt <= '0;
    end else if (filter_done && r_drop && (r_drop_cnt != '1)) begin
      r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
    end
  end

  assign drop_cnt = r_drop_cnt;
`endif

endmodule

// File: tb/tb_fmac_saddr_filter_ctrl.sv
// Directed bench for fmac_saddr_filter_ctrl: latency, decisions, table writes, reset.
module tb_fmac_saddr_filter_ctrl;
  import fmac_saddr_filter_pkg::*;

  localparam int NUM_ENTRIES = 4;
  localparam int IDX_W       = 2;

  logic                  clk;
  logic                  rst_;
  logic                  mcast_en;
  logic                  cfg_wr;
  logic [IDX_W-1:0]      cfg_idx;
  logic [MAC_ADDR_W-1:0] cfg_addr;
  logic                  cfg_ena;
  logic [MAC_ADDR_W-1:0] mac_saddr;
  logic                  mac_saddr_vld;
  logic                  filter_busy;
  logic                  filter_done;
  logic                  saddr_filter_drop;
  logic [IDX_W-1:0]      filter_hit_idx;
  logic [2:0]            dbg_state;
`ifdef FMAC_SADDR_FILTER_STATS_EN
  logic                  drop_cnt_clr;
  logic [DROP_CNT_W-1:0] drop_cnt;
`endif

  int n_run;
  int n_fail;
  int cnt;

  fmac_saddr_filter_ctrl #(
    .NUM_ENTRIES (NUM_ENTRIES),
    .IDX_W       (IDX_W)
  ) dut (
    .clk               (clk),
    .rst_              (rst_),
    .mcast_en          (mcast_en),
    .cfg_wr            (cfg_wr),
    .cfg_idx           (cfg_idx),
    .cfg_addr          (cfg_addr),
    .cfg_ena           (cfg_ena),
    .mac_saddr         (mac_saddr),
    .mac_saddr_vld     (mac_saddr_vld),
`ifdef FMAC_SADDR_FILTER_STATS_EN
    .drop_cnt_clr      (drop_cnt_clr),
    .drop_cnt          (drop_cnt),
`endif
    .filter_busy       (filter_busy),
    .filter_done       (filter_done),
    .saddr_filter_drop (saddr_filter_drop),
    .filter_hit_idx    (filter_hit_idx),
    .dbg_state         (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic wr_entry(input logic [IDX_W-1:0] idx, input logic [47:0] addr, input logic ena);
    cfg_wr   = 1'b1;
    cfg_idx  = idx;
    cfg_addr = addr;
    cfg_ena  = ena;
    tick();
    cfg_wr   = 1'b0;
  endtask

  // Drives vld during cycle 0 and returns at cycle 1 with cnt = 1.
  task automatic start_frame(input string tag, input logic [47:0] addr);
    mac_saddr     = addr;
    mac_saddr_vld = 1'b1;
    tick();
    mac_saddr_vld = 1'b0;
    cnt = 1;
    check({tag, "_busy_c1"}, 48'(filter_busy), 48'd1);
  endtask

  task automatic wait_done(input string tag, input int exp_lat, input logic exp_drop,
                           input logic chk_hit, input logic [IDX_W-1:0] exp_hit);
    while (!filter_done && cnt < 20) begin
      tick();
      cnt++;
    end
    check({tag, "_latency"}, 48'(cnt), 48'(exp_lat));
    check({tag, "_drop"}, 48'(saddr_filter_drop), 48'(exp_drop));
    if (chk_hit) check({tag, "_hit_idx"}, 48'(filter_hit_idx), 48'(exp_hit));
    tick();
    check({tag, "_done_pulse"}, 48'(filter_done), 48'd0);
    check({tag, "_busy_after"}, 48'(filter_busy), 48'd0);
  endtask

  localparam logic [47:0] A_BYP  = 48'h0011_2233_4455;
  localparam logic [47:0] A_MID  = 48'hAABB_CCDD_EEFF;
  localparam logic [47:0] A_MISS = 48'h0000_0000_0001;
  localparam logic [47:0] A_X    = 48'h0102_0304_0506;
  localparam logic [47:0] A_Y    = 48'hDEAD_BEEF_0001;

  initial begin
    logic seen_done;
    n_run = 0;
    n_fail = 0;
    cnt = 0;
    rst_ = 1'b0;
    mcast_en = 1'b0;
    cfg_wr = 1'b0;
    cfg_idx = '0;
    cfg_addr = '0;
    cfg_ena = 1'b0;
    mac_saddr = '0;
    mac_saddr_vld = 1'b0;
`ifdef FMAC_SADDR_FILTER_STATS_EN
    drop_cnt_clr = 1'b0;
`endif
    tick();
    tick();
    check("rst_busy", 48'(filter_busy), 48'd0);
    check("rst_done", 48'(filter_done), 48'd0);
    check("rst_drop", 48'(saddr_filter_drop), 48'd0);
    check("rst_hit", 48'(filter_hit_idx), 48'd0);
    check("rst_state", 48'(dbg_state), 48'(ST_IDLE));
    rst_ = 1'b1;
    tick();

    // bypass: done at cycle 1, busy low at cycle 2
    mcast_en = 1'b0;
    start_frame("byp", A_BYP);
    wait_done("byp", 1, 1'b0, 1'b1, 2'd0);

    // hit in the middle of the table
    wr_entry(2'd2, A_MID, 1'b1);
    mcast_en = 1'b1;
    start_frame("mid", A_MID);
    wait_done("mid", 4, 1'b0, 1'b1, 2'd2);
    repeat (3) tick();
    check("hold_hit_idx", 48'(filter_hit_idx), 48'd2);

    // full miss with every entry enabled, then with all disabled
    wr_entry(2'd0, 48'h1111_1111_1111, 1'b1);
    wr_entry(2'd1, 48'h2222_2222_2222, 1'b1);
    wr_entry(2'd3, 48'h4444_4444_4444, 1'b1);
    start_frame("miss", A_MISS);
    wait_done("miss", 5, 1'b1, 1'b0, 2'd0);
    for (int i = 0; i < NUM_ENTRIES; i++) wr_entry(IDX_W'(i), 48'h1111_1111_1111, 1'b0);
    start_frame("empty", A_MISS);
    wait_done("empty", 5, 1'b1, 1'b0, 2'd0);

    // disabled entry 0 matches but must be skipped; enabled entry 3 wins
    wr_entry(2'd0, A_X, 1'b0);
    wr_entry(2'd3, A_X, 1'b1);
    start_frame("dis", A_X);
    wait_done("dis", 5, 1'b0, 1'b1, 2'd3);

    // write to entry 1 while it is being compared: old contents used
    start_frame("coll", A_Y);
    tick();
    cnt++;
    cfg_wr = 1'b1;
    cfg_idx = 2'd1;
    cfg_addr = A_Y;
    cfg_ena = 1'b1;
    tick();
    cnt++;
    cfg_wr = 1'b0;
    wait_done("coll", 5, 1'b1, 1'b0, 2'd0);
    start_frame("coll2", A_Y);
    wait_done("coll2", 3, 1'b0, 1'b1, 2'd1);

    // mcast_en dropped mid-scan does not turn the frame into a bypass
    start_frame("mc_mid", A_X);
    mcast_en = 1'b0;
    tick();
    cnt++;
    wait_done("mc_mid", 5, 1'b0, 1'b1, 2'd3);
    mcast_en = 1'b1;

    // reset at cycle 2 of a scan: no done, outputs cleared, entries disabled
    start_frame("rstmid", A_MISS);
    tick();
    rst_ = 1'b0;
    #1;
    check("rstmid_busy", 48'(filter_busy), 48'd0);
    check("rstmid_drop", 48'(saddr_filter_drop), 48'd0);
    check("rstmid_hit", 48'(filter_hit_idx), 48'd0);
    check("rstmid_state", 48'(dbg_state), 48'(ST_IDLE));
    seen_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (filter_done) seen_done = 1'b1;
    end
    check("rstmid_no_done", 48'(seen_done), 48'd0);
    rst_ = 1'b1;
    tick();
    start_frame("post_rst", A_Y);
    wait_done("post_rst", 5, 1'b1, 1'b0, 2'd0);

`ifdef FMAC_SADDR_FILTER_STATS_EN
    check("stats_cnt", 48'(drop_cnt), 48'd1);
    drop_cnt_clr = 1'b1;
    tick();
    drop_cnt_clr = 1'b0;
    check("stats_clr", 48'(drop_cnt), 48'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
